// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: error codes and FSM state encodings shared by the UART frame receiver.
package uart_frame_pkg;
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_FRAMING  = 3'd1;
    localparam logic [2:0] ERR_BAD_ETX  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;
    localparam logic [2:0] ERR_CHECKSUM = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHK, S_ETX} frame_state_e;
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_e;
endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: payload valid/ready port plus error and status outputs of uart_frame_rx.
interface uart_frame_rx_if #(
    parameter int PAYLOAD_BYTES = 6
);
    logic [PAYLOAD_BYTES*8-1:0] frame_data;
    logic                       frame_valid;
    logic                       frame_ready;
    logic                       frame_err;
    logic [2:0]                 err_code;
    logic                       busy;
    modport master (output frame_data, frame_valid, frame_err, err_code, busy, input frame_ready);
    modport slave (input frame_data, frame_valid, frame_err, err_code, busy, output frame_ready);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-FF synchronised 8N1 byte receiver with start-bit glitch rejection and framing-error flag.
module uart_byte_rx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       framing_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [2:0]    sync_q;
    byte_state_e   st_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx;
    logic          tick;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
    assign rx   = sync_q[1];
    assign tick = cnt_q == (st_q == B_START ? HALF_M1 : FULL_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 3'b111;
            st_q    <= B_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx_i};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= (st_q == B_IDLE || tick) ? '0 : cnt_q + 1'b1;
            case (st_q)
                B_IDLE:  if (sync_q[2] && !rx) st_q <= B_START;
                B_START: if (tick) st_q <= rx ? B_IDLE : B_DATA;
                B_DATA:  if (tick) begin
                    sh_q  <= {rx, sh_q[7:1]};
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) st_q <= B_STOP;
                end
                default: if (tick) begin
                    st_q    <= B_IDLE;
                    valid_q <= rx;
                    ferr_q  <= !rx;
                end
            endcase
        end
    end

    assign byte_valid_o  = valid_q;
    assign byte_o        = sh_q;
    assign framing_err_o = ferr_q;
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: STX|payload|[chk]|ETX frame receiver with valid/ready payload port and error reporting.
// Define UART_FRAME_CHECKSUM_EN to expect an XOR-of-payload byte between the payload and ETX.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = 434,
    parameter int         PAYLOAD_BYTES  = 6,
    parameter logic [7:0] STX_BYTE       = 8'h02,
    parameter logic [7:0] ETX_BYTE       = 8'h03,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input logic             clk,
    input logic             rst,
    input logic             rx_in,
    uart_frame_rx_if.master bus
);
    localparam int IW = $clog2(PAYLOAD_BYTES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic                       bv;
    logic                       ferr;
    logic [7:0]                 rx_byte;
    frame_state_e               state_q;
    logic [IW-1:0]              idx_q;
    logic [WW-1:0]              wd_q;
    logic [PAYLOAD_BYTES*8-1:0] buf_q;
    logic [PAYLOAD_BYTES*8-1:0] data_q;
    logic                       valid_q;
    logic                       err_q;
    logic [2:0]                 code_q;
    logic                       timeout;
    logic                       last;
    logic                       accept;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]                 chk_q;
`endif

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_in),
        .byte_valid_o (bv),
        .byte_o       (rx_byte),
        .framing_err_o(ferr)
    );

    // a byte arriving in the same cycle the watchdog expires wins over the timeout
    assign timeout = state_q != S_IDLE && !bv && wd_q == WW'(TIMEOUT_CYCLES - 1);
    assign last    = idx_q == IW'(PAYLOAD_BYTES - 1);
    assign accept  = !valid_q || bus.frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            wd_q   <= (state_q == S_IDLE || bv) ? '0 : wd_q + 1'b1;
            if (valid_q && bus.frame_ready) valid_q <= 1'b0;
            if (ferr || timeout) begin
                err_q   <= 1'b1;
                code_q  <= ferr ? ERR_FRAMING : ERR_TIMEOUT;
                state_q <= S_IDLE;
            end else if (bv) begin
                case (state_q)
                    S_IDLE: if (rx_byte == STX_BYTE) begin
                        state_q <= S_PAYLOAD;
                        idx_q   <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        chk_q   <= '0;
`endif
                    end
                    S_PAYLOAD: begin
                        buf_q[idx_q*8 +: 8] <= rx_byte;
                        idx_q <= idx_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                        chk_q <= chk_q ^ rx_byte;
                        if (last) state_q <= S_CHK;
`else
                        if (last) state_q <= S_ETX;
`endif
                    end
`ifdef UART_FRAME_CHECKSUM_EN
                    S_CHK: begin
                        state_q <= rx_byte == chk_q ? S_ETX : S_IDLE;
                        err_q   <= rx_byte != chk_q;
                        code_q  <= rx_byte != chk_q ? ERR_CHECKSUM : ERR_NONE;
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                        if (rx_byte != ETX_BYTE) begin
                            err_q  <= 1'b1;
                            code_q <= ERR_BAD_ETX;
                        end else if (accept) begin
                            data_q  <= buf_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_OVERRUN;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.frame_data  = data_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.err_code    = code_q;
    assign bus.busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames against a queue-based frame/error model checked every cycle.
module tb_uart_frame_rx;
    import uart_frame_pkg::*;
    localparam int CPB = 16;
    localparam int PB  = 6;
    localparam int TO  = 1000;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #5 clk = ~clk;

    uart_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus ();

    uart_frame_rx #(
        .CLKS_PER_BIT  (CPB),
        .PAYLOAD_BYTES (PB),
        .STX_BYTE      (STX),
        .ETX_BYTE      (ETX),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_in(rx),
        .bus  (bus)
    );

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_bv = 0;
    int err_cyc = 0;
    int err_seen = 0;
    int frames_seen = 0;
    logic [2:0] last_code = '0;
    logic [PB*8-1:0] last_data = '0;
    logic [PB*8-1:0] exp_frames[$];
    logic [2:0] exp_errs[$];
    bit held = 1'b0;

    task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Frame-level model: a well-formed frame yields its payload, otherwise the first rule it breaks.
    function automatic void model_frame(input logic [7:0] f[$]);
        logic [PB*8-1:0] d = '0;
        logic [7:0] c = '0;
        int n = 1;
        for (int i = 0; i < PB; i++) begin
            d[i*8 +: 8] = f[n];
            c ^= f[n];
            n++;
        end
`ifdef UART_FRAME_CHECKSUM_EN
        if (f[n] != c) begin
            exp_errs.push_back(ERR_CHECKSUM);
            return;
        end
        n++;
`endif
        if (f[n] != ETX) exp_errs.push_back(ERR_BAD_ETX);
        else if (held) exp_errs.push_back(ERR_OVERRUN);
        else begin
            exp_frames.push_back(d);
            held = !bus.frame_ready;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [PB*8-1:0] p, input logic [7:0] etx = ETX, input int chk = -1);
        logic [7:0] f[$];
        logic [7:0] c = '0;
        f.push_back(STX);
        for (int i = 0; i < PB; i++) begin
            f.push_back(p[i*8 +: 8]);
            c ^= p[i*8 +: 8];
        end
`ifdef UART_FRAME_CHECKSUM_EN
        f.push_back(chk < 0 ? c : 8'(chk));
`endif
        f.push_back(etx);
        model_frame(f);
        foreach (f[i]) send_byte(f[i]);
        repeat (2 * CPB) @(negedge clk);
    endtask

    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    logic [PB*8-1:0] prev_d = '0;
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (dut.u_byte.byte_valid_o) last_bv = cyc;
        if (!rst) begin
            if (bus.frame_err) begin
                checks++;
                err_cyc = cyc;
                err_seen++;
                last_code = bus.err_code;
                if (exp_errs.size() == 0) begin
                    fails++;
                    $display("FAIL err_unexpected got=%0d want=none", bus.err_code);
                end else begin
                    if (bus.err_code !== exp_errs[0]) begin
                        fails++;
                        $display("FAIL err_code got=%0d want=%0d", bus.err_code, exp_errs[0]);
                    end
                    void'(exp_errs.pop_front());
                end
            end
            if (bus.frame_valid && (!prev_v || prev_hs)) begin
                checks++;
                frames_seen++;
                last_data = bus.frame_data;
                if (exp_frames.size() == 0) begin
                    fails++;
                    $display("FAIL frame_unexpected got=%0h want=none", bus.frame_data);
                end else begin
                    if (bus.frame_data !== exp_frames[0]) begin
                        fails++;
                        $display("FAIL frame_data got=%0h want=%0h", bus.frame_data, exp_frames[0]);
                    end
                    void'(exp_frames.pop_front());
                end
            end
            if (prev_v && !prev_hs) begin
                checks++;
                if (!bus.frame_valid || bus.frame_data !== prev_d) begin
                    fails++;
                    $display("FAIL frame_hold got=%0b/%0h want=1/%0h", bus.frame_valid, bus.frame_data, prev_d);
                end
            end
        end
        prev_v  = bus.frame_valid;
        prev_hs = bus.frame_valid && bus.frame_ready;
        prev_d  = bus.frame_data;
    end

    initial begin
        int f0;
        int e0;
        bus.frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        expect_eq("rst_valid", bus.frame_valid, 0);
        expect_eq("rst_err", bus.frame_err, 0);
        expect_eq("rst_code", bus.err_code, 0);
        expect_eq("rst_busy", bus.busy, 0);
        expect_eq("rst_data", bus.frame_data, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(48'h665544332211);
        expect_eq("t1_frames", frames_seen, 1);
        expect_eq("t1_data", last_data, 48'h665544332211);
        expect_eq("t1_noerr", err_seen, 0);

        send_frame(48'h665544332211, 8'h04);
        expect_eq("t2_code", last_code, 2);
        expect_eq("t2_noframe", frames_seen, 1);
        send_frame(48'h0f0e0d0c020a);
        expect_eq("t2_next", last_data, 48'h0f0e0d0c020a);

        exp_errs.push_back(ERR_TIMEOUT);
        send_byte(STX);
        send_byte(8'h11);
        send_byte(8'h22);
        e0 = err_seen;
        for (int i = 0; i < 2 * TO && err_seen == e0; i++) @(negedge clk);
        expect_eq("t3_fired", err_seen, e0 + 1);
        expect_eq("t3_code", last_code, 3);
        // error registers on the TO-th edge after the edge that consumed the last byte
        expect_eq("t3_delay", err_cyc - last_bv, TO + 1);
        expect_eq("t3_busy", bus.busy, 0);
        f0 = frames_seen;
        send_frame(48'h060504030201);
        expect_eq("t3_next", frames_seen, f0 + 1);

        bus.frame_ready = 1'b0;
        send_frame(48'ha5a4a3a2a1a0);
        send_frame(48'hb5b4b3b2b1b0);
        expect_eq("t4_code", last_code, 4);
        expect_eq("t4_valid", bus.frame_valid, 1);
        expect_eq("t4_data", bus.frame_data, 48'ha5a4a3a2a1a0);
        bus.frame_ready = 1'b1;
        held = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("t4_release", bus.frame_valid, 0);

        e0 = err_seen;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expect_eq("t5_glitch_err", err_seen, e0);
        expect_eq("t5_glitch_busy", bus.busy, 0);
        send_byte(STX);
        send_byte(8'h11);
        exp_errs.push_back(ERR_FRAMING);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        expect_eq("t5_code", last_code, 1);
        expect_eq("t5_busy", bus.busy, 0);
        f0 = frames_seen;
        send_frame(48'h112233445566);
        expect_eq("t5_next", frames_seen, f0 + 1);

        e0 = err_seen;
        send_byte(STX);
        send_byte(8'h77);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        expect_eq("rst_mid_busy", bus.busy, 0);
        expect_eq("rst_mid_err", err_seen, e0);

`ifdef UART_FRAME_CHECKSUM_EN
        send_frame(48'h201008040201, ETX, 8'h3F);
        expect_eq("t6_data", last_data, 48'h201008040201);
        send_frame(48'h201008040201, ETX, 8'h3E);
        expect_eq("t6_code", last_code, 5);
`endif

        expect_eq("frames_left", exp_frames.size(), 0);
        expect_eq("errs_left", exp_errs.size(), 0);
        expect_eq("end_busy", bus.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
